// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cached memory port between the I-fetch and data requesters.
// Latency: a request sampled at edge N shows its strobe after N; m_ready sampled at M gives x_ready in cycle M+1.
// Backpressure: requests are level-held until x_ready; only one transaction is in flight, and one idle cycle follows it.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   i_req/i_addr          - instruction fetch request; i_rdata/i_ready return it
//   d_read/d_write/d_addr/d_wdata - data request; d_rdata/d_ready return it
//   m_read/m_write/m_addr/m_wdata/m_rdata/m_ready - downstream memory port
//   busy                  - high from the issue cycle through the response cycle
//   m_err                 - timeout flag on the ready pulse (only with ARB_TIMEOUT_EN)
//
// Build option: define ARB_TIMEOUT_EN to bound the wait for m_ready to TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              m_err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D, RESP} state_t;

  state_t state;
  logic   last_d;   // 1 when D received the most recent grant
  logic   d_req;
  logic   grant_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  // The TIMEOUT-th ISSUE cycle without m_ready ends the transaction.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  assign d_req   = d_read | d_write;
  // D wins when alone, or under contention when I was granted last.
  assign grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      i_rdata <= '0;
      i_ready <= 1'b0;
      d_rdata <= '0;
      d_ready <= 1'b0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt <= '0;
      m_err    <= 1'b0;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      m_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (grant_d) begin
            state   <= ISSUE_D;
            last_d  <= 1'b1;
            busy    <= 1'b1;
            // Read and write together is treated as a write.
            m_read  <= d_read & ~d_write;
            m_write <= d_write;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (i_req) begin
            state  <= ISSUE_I;
            last_d <= 1'b0;
            busy   <= 1'b1;
            m_read <= 1'b1;
            m_addr <= i_addr;
          end
        end

        ISSUE_I, ISSUE_D: begin
          if (m_ready) begin
            state   <= RESP;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (state == ISSUE_I) begin
              i_ready <= 1'b1;
              i_rdata <= m_rdata;
            end else begin
              d_ready <= 1'b1;
              if (m_read) d_rdata <= m_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (timed_out) begin
            // Abandon the access: pulse ready with m_err, keep rdata.
            state   <= RESP;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_err   <= 1'b1;
            if (state == ISSUE_I) i_ready <= 1'b1;
            else                  d_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        // One cycle with both strobes low before the next grant.
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        busy;
`ifdef ARB_TIMEOUT_EN
  logic        m_err;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_read  (m_read),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .busy    (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .m_err   (m_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          side;   // 0 = I, 1 = D
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_read"},  m_read,  0);
    chk({tag, "_m_write"}, m_write, 0);
    chk({tag, "_m_addr"},  m_addr,  0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_i_ready"}, i_ready, 0);
    chk({tag, "_d_ready"}, d_ready, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_busy"},    busy,    0);
`ifdef ARB_TIMEOUT_EN
    chk({tag, "_m_err"},   m_err,   0);
`endif
  endtask

  // Wait for the next downstream transaction, check it against the scoreboard
  // head, complete it after lat strobe cycles, and check the ready pulse.
  task automatic serve(input int lat, input logic [31:0] rd);
    exp_t e;
    bit   seen;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e    = sb.pop_front();
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clock);
      seen = m_read | m_write;
    end
    chk("strobe_seen", seen, 1);
    if (!seen) return;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clock);
      chk("m_read",  m_read,  e.wr ? 0 : 1);
      chk("m_write", m_write, e.wr ? 1 : 0);
      chk("m_addr",  m_addr,  e.addr);
      if (e.wr) chk("m_wdata", m_wdata, e.wdata);
      chk("busy_issue", busy, 1);
      chk("no_ready_issue", i_ready | d_ready, 0);
    end
    m_ready = 1'b1;
    m_rdata = rd;
    @(negedge clock);
    m_ready = 1'b0;
    m_rdata = $urandom;
    if (!e.wr) begin
      if (e.side) exp_d_rdata = rd;
      else        exp_i_rdata = rd;
    end
    if (e.side) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_req = 1'b0;
    end
    chk("resp_strobes", m_read | m_write, 0);
    chk("i_ready", i_ready, e.side ? 0 : 1);
    chk("d_ready", d_ready, e.side ? 1 : 0);
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("busy_resp", busy, 1);
`ifdef ARB_TIMEOUT_EN
    chk("m_err_ok", m_err, 0);
`endif
    @(negedge clock);
    chk("ready_pulse_end", i_ready | d_ready, 0);
    chk("gap_strobes", m_read | m_write, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_ready = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // m_ready while idle must not produce a pulse
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
    chk("idle_mready_i", i_ready, 0);
    chk("idle_mready_d", d_ready, 0);
    chk("idle_mready_busy", busy, 0);

    // single I read
    i_req  = 1'b1;
    i_addr = 32'h100;
    sb.push_back('{side: 1'b0, wr: 1'b0, addr: 32'h100, wdata: 32'h0});
    serve(3, 32'hDEADBEEF);

    // contention after reset pointer: D first, then I; D re-requests while
    // I is pending and loses because it was granted last
    i_req  = 1'b1;
    i_addr = 32'h100;
    d_read = 1'b1;
    d_addr = 32'h200;
    sb.push_back('{side: 1'b1, wr: 1'b0, addr: 32'h200, wdata: 32'h0});
    sb.push_back('{side: 1'b0, wr: 1'b0, addr: 32'h100, wdata: 32'h0});
    sb.push_back('{side: 1'b1, wr: 1'b0, addr: 32'h300, wdata: 32'h0});
    serve(2, 32'hA5A50001);
    d_read = 1'b1;
    d_addr = 32'h300;
    serve(1, 32'h5A5A0002);
    serve(4, 32'h0BADF00D);

    // D write: d_rdata must keep the last read value
    d_write = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'h12345678;
    sb.push_back('{side: 1'b1, wr: 1'b1, addr: 32'h40, wdata: 32'h12345678});
    serve(3, 32'hFFFFFFFF);

    // read and write together: write only
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h44;
    d_wdata = 32'h87654321;
    sb.push_back('{side: 1'b1, wr: 1'b1, addr: 32'h44, wdata: 32'h87654321});
    serve(2, 32'hEEEEEEEE);

    // reset during ISSUE_D with an I request pending
    d_read = 1'b1;
    d_addr = 32'h500;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clock);
        seen = m_read;
      end
      chk("rst_issue_seen", seen, 1);
      chk("rst_issue_addr", m_addr, 32'h500);
    end
    i_req  = 1'b1;
    i_addr = 32'h180;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    @(negedge clock);
    reset  = 1'b0;
    d_read = 1'b0;
    sb.push_back('{side: 1'b0, wr: 1'b0, addr: 32'h180, wdata: 32'h0});
    serve(2, 32'hCAFEF00D);

`ifdef ARB_TIMEOUT_EN
    // no m_ready: strobe for 64 cycles, then ready with m_err
    i_req  = 1'b1;
    i_addr = 32'h600;
    begin
      int hi = 0;
      bit done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
        @(negedge clock);
        if (m_read) hi++;
        else if (hi > 0) done = 1'b1;
      end
      chk("to_cycles", hi, 64);
      chk("to_i_ready", i_ready, 1);
      chk("to_m_err", m_err, 1);
      chk("to_i_rdata", i_rdata, exp_i_rdata);
      i_req = 1'b0;
      @(negedge clock);
      chk("to_ready_end", i_ready, 0);
      chk("to_err_end", m_err, 0);
      chk("to_busy_end", busy, 0);
    end
`endif

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single cached memory port (the cache/RAM controller's read/write/ready interface) between the instruction-fetch (I) and data (D) requesters of the MIPS core.
- Accepts level-held requests from both sides, arbitrates round-robin, and drives one transaction at a time downstream.
- Returns a one-cycle ready pulse plus registered read data to the winning requester.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 64, maximum cycles to wait for m_ready (used only with ARB_TIMEOUT_EN).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  instruction fetch request, held until i_ready.
- i_addr  input  ADDR_W  fetch address.
- i_rdata  output  DATA_W  fetched word, valid while i_ready=1, held afterwards.
- i_ready  output  1  one-cycle completion pulse for I.
- d_read  input  1  data read request, held until d_ready.
- d_write  input  1  data write request, held until d_ready.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_rdata  output  DATA_W  read word, valid while d_ready=1, held afterwards.
- d_ready  output  1  one-cycle completion pulse for D.
- m_read  output  1  downstream read strobe, held until m_ready.
- m_write  output  1  downstream write strobe, held until m_ready.
- m_addr  output  ADDR_W  downstream address, stable during the transaction.
- m_wdata  output  DATA_W  downstream write data.
- m_rdata  input  DATA_W  downstream read data, valid with m_ready.
- m_ready  input  1  downstream completion pulse.
- busy  output  1  high from the issue cycle through the RESP cycle.

Behaviour:
- Reset value of every output is 0, applied asynchronously and immediately, including mid-transaction. The round-robin pointer resets to last=I, so D wins the first contention.
- All outputs are registered.
- States:
  - IDLE: m_read=0, m_write=0; sample requests.
  - ISSUE_I: m_read=1, m_addr=i_addr latched.
  - ISSUE_D: m_read=d_read & ~d_write, or m_write=d_write; addr and wdata latched.
  - RESP: m_* strobes low, ready pulse high.
- IDLE transitions:
  - Only I requesting -> ISSUE_I.
  - Only D requesting (d_read|d_write) -> ISSUE_D.
  - Both requesting -> the side not granted last; pointer updated on grant.
  - None requesting -> stay in IDLE.
- ISSUE_x: hold strobes, address and wdata constant. When m_ready is sampled high, capture m_rdata into x_rdata (reads only), go to RESP, and assert x_ready for exactly that cycle.
- RESP -> IDLE unconditionally. This guarantees at least one cycle with both m_read and m_write low between transactions, which the downstream controller requires to return to its idle state.
- Latency:
  - Request sampled at edge N -> strobe visible after edge N.
  - m_ready sampled at edge M -> x_ready visible for cycle M+1.
  - Back-to-back requests from one side have a minimum period of issue + downstream latency + 2 cycles.
- d_read and d_write both high: treated as a write. m_read stays 0.
- A requester dropping its request mid-transaction does not abort it. The downstream transaction completes and the ready pulse is still issued.
- Request inputs are not sampled outside IDLE. A new request seen in RESP waits for IDLE.
- Writes leave d_rdata unchanged.
- m_ready seen while in IDLE or RESP is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - Adds output port m_err (1 bit).
  - An 8-bit-minimum counter clears on entry to ISSUE_x and increments each ISSUE cycle.
  - If it reaches TIMEOUT without m_ready, the strobes drop, the FSM goes to RESP, x_ready pulses with m_err=1 for the same single cycle, and x_rdata is left unchanged.
  - m_err=0 on normal completion and after reset.
- When undefined: no counter, no m_err port, and ISSUE waits indefinitely.

Test Plan:
- Single I read: i_req=1, i_addr=0x100, m_ready after 3 cycles with m_rdata=0xDEADBEEF -> m_read=1 with m_addr=0x100 for 3 cycles, then i_ready pulses once with i_rdata=0xDEADBEEF, busy falls one cycle later.
- Simultaneous after reset: i_req=1 and d_read=1 in the same cycle -> D served first (addr 0x200), then I (addr 0x100), with one gap cycle of m_read=0 between them. The next contention grants I first.
- D write: d_write=1, d_addr=0x40, d_wdata=0x12345678 -> m_write=1 with those values until m_ready, then d_ready pulse, m_read never 1, d_rdata unchanged.
- Read+write conflict: d_read=1 and d_write=1 -> only m_write asserted.
- Reset mid-transaction: assert reset during ISSUE_D -> all outputs 0 within the same cycle. After release, a pending i_req is served (pointer back to last=I is irrelevant because there is no contention).
- ARB_TIMEOUT_EN, TIMEOUT=64, m_ready never asserted: i_req=1 -> m_read drops after 64 cycles, i_ready=1 and m_err=1 for one cycle, FSM returns to IDLE.
